level_tone_out: RTL and testbench

Audio-output companion to the decibel level meter. It takes the 4-bit loudness level and its one-cycle update strobe, and turns them into a square-wave tone whose pitch and amplitude rise with level. It writes stereo samples into the audio controller's output FIFO through the `write_audio_out`/`audio_out_allowed` handshake. It sits between the level counter and the audio controller's DAC path.

---
 rtl/tone_pkg.sv | 30 +++
 rtl/level_latch_wd.sv | 46 ++++
 rtl/level_tone_out.sv | 119 +++++++++++
 tb/tb_level_tone_out.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tone_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tone_pkg
// Description : Shared constants, write-FSM states and half-period table for
//               the level-to-tone audio output path.
// Revision    : 1.0 - initial release
// ============================================================================
package tone_pkg;

    localparam logic [3:0] LEVEL_MAX = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_GAP   = 2'd2
    } wr_state_t;

    // Half-period in samples: 44 at level 1 down to 12 at level 9; level 0 is silent.
    function automatic logic [5:0] HALF_PERIOD(input logic [3:0] lvl);
        logic [5:0] half;
        if ((lvl == 4'd0) || (lvl > LEVEL_MAX)) begin
            half = 6'd0;
        end else begin
            half = 6'd48 - {lvl, 2'b00};
        end
        return half;
    endfunction

endpackage
`default_nettype wire

// File: rtl/level_latch_wd.sv
`default_nettype none
// ============================================================================
// Module      : level_latch_wd
// Description : Captures valid loudness levels and forces the pending level
//               to silence when no update arrives within the timeout window.
// Revision    : 1.0 - initial release
// ============================================================================
module level_latch_wd
    import tone_pkg::*;
#(
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd100000000
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [3:0] level,
    input  logic       level_valid,
    output logic [3:0] pend_level
);

    logic [31:0] r_wd;
    logic [3:0]  r_pend_level;
    logic        w_expired;

    assign w_expired = (r_wd >= (TIMEOUT_CYCLES - 32'd1));

    // An out-of-range level still proves the meter is alive, so it clears the watchdog.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_wd         <= 32'd0;
            r_pend_level <= 4'd0;
        end else if (level_valid) begin
            r_wd <= 32'd0;
            if (level <= LEVEL_MAX) begin
                r_pend_level <= level;
            end
        end else if (w_expired) begin
            r_pend_level <= 4'd0;
        end else begin
            r_wd <= r_wd + 32'd1;
        end
    end

    assign pend_level = r_pend_level;

endmodule
`default_nettype wire

// File: rtl/level_tone_out.sv
`default_nettype none
// ============================================================================
// Module      : level_tone_out
// Description : Converts the loudness level into a square-wave tone and writes
//               stereo samples to the audio controller output FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module level_tone_out
    import tone_pkg::*;
#(
    parameter logic [31:0] AMP_STEP       = 32'd100000000,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd100000000
) (
    input  logic               CLOCK_50,
    input  logic               reset,
    input  logic [3:0]         level,
    input  logic               level_valid,
    input  logic               enable,
    input  logic               audio_out_allowed,
    output logic               write_audio_out,
    output logic signed [31:0] left_channel_audio_out,
    output logic signed [31:0] right_channel_audio_out,
    output logic [3:0]         cur_level,
    output logic               muted
);

    wr_state_t          r_state;
    wr_state_t          w_state_nxt;
    logic               w_issue;
    logic [3:0]         w_pend_level;
    logic [3:0]         r_cur_level;
    logic               r_ph;
    logic [5:0]         r_sc;
    logic               r_write;
    logic               r_muted;
    logic signed [31:0] r_sample;
    logic [5:0]         w_half;
    logic               w_boundary;
    logic [31:0]        w_amp;
    logic signed [31:0] w_sample;

    level_latch_wd #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_level_latch_wd (
        .CLOCK_50    (CLOCK_50),
        .reset       (reset),
        .level       (level),
        .level_valid (level_valid),
        .pend_level  (w_pend_level)
    );

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // GAP also acts as the decision cycle, so sustained writes land every other cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        case (r_state)
            ST_IDLE, ST_GAP: begin
                if (enable && audio_out_allowed) begin
                    w_state_nxt = ST_WRITE;
                    w_issue     = 1'b1;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WRITE: begin
                w_state_nxt = enable ? ST_GAP : ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign w_half     = HALF_PERIOD(r_cur_level);
    assign w_boundary = (r_cur_level == 4'd0) || (r_sc == (w_half - 6'd1));
    assign w_amp      = {28'd0, r_cur_level} * AMP_STEP;
    assign w_sample   = r_ph ? $signed(w_amp) : -$signed(w_amp);

    // Sample is built from the pre-update level/phase; level changes only at half-period edges.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_write     <= 1'b0;
            r_sample    <= 32'sd0;
            r_cur_level <= 4'd0;
            r_muted     <= 1'b1;
            r_ph        <= 1'b0;
            r_sc        <= 6'd0;
        end else begin
            r_write <= w_issue;
            if (w_issue) begin
                r_sample <= w_sample;
                if (w_boundary) begin
                    r_sc        <= 6'd0;
                    r_cur_level <= w_pend_level;
                    r_muted     <= (w_pend_level == 4'd0);
                    r_ph        <= (w_pend_level == 4'd0) ? 1'b0 : ~r_ph;
                end else begin
                    r_sc <= r_sc + 6'd1;
                end
            end
        end
    end

    assign write_audio_out         = r_write;
    assign left_channel_audio_out  = r_sample;
    assign right_channel_audio_out = r_sample;
    assign cur_level               = r_cur_level;
    assign muted                   = r_muted;

endmodule
`default_nettype wire

// File: tb/tb_level_tone_out.sv
`default_nettype none
// ============================================================================
// Module      : tb_level_tone_out
// Description : Scoreboard bench for level_tone_out tone generation and handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_level_tone_out;

    localparam int          A   = 100000000;
    localparam logic [31:0] TMO = 32'd1000;

    logic               CLOCK_50 = 1'b0;
    logic               reset = 1'b1;
    logic [3:0]         level = 4'd0;
    logic               level_valid = 1'b0;
    logic               enable = 1'b0;
    logic               audio_out_allowed = 1'b0;
    logic               write_audio_out;
    logic signed [31:0] left_out;
    logic signed [31:0] right_out;
    logic [3:0]         cur_level;
    logic               muted;

    int tests_run = 0;
    int tests_failed = 0;
    int cycle = 0;
    int writes_seen = 0;
    bit sb_on = 1'b0;
    logic signed [31:0] sb_q[$];
    logic signed [31:0] exp_s;

    level_tone_out #(
        .AMP_STEP       (32'd100000000),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .CLOCK_50                (CLOCK_50),
        .reset                   (reset),
        .level                   (level),
        .level_valid             (level_valid),
        .enable                  (enable),
        .audio_out_allowed       (audio_out_allowed),
        .write_audio_out         (write_audio_out),
        .left_channel_audio_out  (left_out),
        .right_channel_audio_out (right_out),
        .cur_level               (cur_level),
        .muted                   (muted)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    always @(posedge CLOCK_50) cycle <= cycle + 1;

    // Scoreboard: every write pops the next expected sample.
    always @(negedge CLOCK_50) begin
        if (write_audio_out === 1'b1) begin
            writes_seen++;
            if (sb_on) begin
                tests_run++;
                if (sb_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL sb_underflow: unexpected write, left=%0d required no write", left_out);
                end else begin
                    exp_s = sb_q.pop_front();
                    if (left_out !== exp_s) begin
                        tests_failed++;
                        $display("FAIL sb_left: write %0d got %0d required %0d", writes_seen, left_out, exp_s);
                    end
                    tests_run++;
                    if (right_out !== exp_s) begin
                        tests_failed++;
                        $display("FAIL sb_right: write %0d got %0d required %0d", writes_seen, right_out, exp_s);
                    end
                end
            end
        end
    end

    task automatic push_n(input int v, input int n);
        for (int i = 0; i < n; i++) sb_q.push_back(v);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge CLOCK_50);
        #1;
    endtask

    task automatic strobe(input logic [3:0] v);
        @(posedge CLOCK_50); #1;
        level = v;
        level_valid = 1'b1;
        @(posedge CLOCK_50); #1;
        level_valid = 1'b0;
        idle(1);
    endtask

    // Lets exactly n writes through, then closes the gate named by use_en.
    task automatic run_writes(input int n, input bit use_en, output bit to,
                              output int first_c, output int last_c);
        int target;
        target  = writes_seen + n;
        to      = 1'b1;
        first_c = -1;
        last_c  = -1;
        audio_out_allowed = 1'b1;
        enable = 1'b1;
        for (int i = 0; i < 4 * n + 20; i++) begin
            @(negedge CLOCK_50); #1;
            if (write_audio_out && first_c < 0) first_c = cycle;
            if (writes_seen >= target) begin
                to = 1'b0;
                last_c = cycle;
                break;
            end
        end
        if (use_en) enable = 1'b0;
        else audio_out_allowed = 1'b0;
        idle(3);
    endtask

    task automatic test_reset;
        idle(3);
        tests_run++; if (write_audio_out !== 1'b0) begin tests_failed++; $display("FAIL rst_write: got %b required 0", write_audio_out); end
        tests_run++; if (left_out !== 32'sd0) begin tests_failed++; $display("FAIL rst_left: got %0d required 0", left_out); end
        tests_run++; if (right_out !== 32'sd0) begin tests_failed++; $display("FAIL rst_right: got %0d required 0", right_out); end
        tests_run++; if (cur_level !== 4'd0) begin tests_failed++; $display("FAIL rst_level: got %0d required 0", cur_level); end
        tests_run++; if (muted !== 1'b1) begin tests_failed++; $display("FAIL rst_muted: got %b required 1", muted); end
        reset = 1'b0;
        idle(2);
        tests_run++; if (write_audio_out !== 1'b0) begin tests_failed++; $display("FAIL idle_write: got %b required 0", write_audio_out); end
    endtask

    task automatic test_silent_writes;
        bit to; int f; int l;
        sb_on = 1'b1;
        push_n(0, 4);
        run_writes(4, 1'b0, to, f, l);
        tests_run++; if (to) begin tests_failed++; $display("FAIL silent_timeout: got timeout required 4 writes"); end
        tests_run++; if ((l - f) !== 6) begin tests_failed++; $display("FAIL silent_spacing: got %0d cycles required 6", l - f); end
        tests_run++; if (muted !== 1'b1) begin tests_failed++; $display("FAIL silent_muted: got %b required 1", muted); end
    endtask

    task automatic test_level_one;
        bit to; int f; int l;
        strobe(4'd1);
        push_n(0, 1);
        push_n(A, 44);
        push_n(-A, 44);
        push_n(A, 4);
        run_writes(93, 1'b0, to, f, l);
        tests_run++; if (to) begin tests_failed++; $display("FAIL l1_timeout: got timeout required 93 writes"); end
        tests_run++; if (cur_level !== 4'd1) begin tests_failed++; $display("FAIL l1_level: got %0d required 1", cur_level); end
        tests_run++; if (muted !== 1'b0) begin tests_failed++; $display("FAIL l1_muted: got %b required 0", muted); end
    endtask

    task automatic test_level_nine_mid;
        bit to; int f; int l;
        strobe(4'd9);
        push_n(A, 40);
        push_n(-9 * A, 12);
        push_n(9 * A, 12);
        push_n(-9 * A, 12);
        run_writes(39, 1'b0, to, f, l);
        tests_run++; if (cur_level !== 4'd1) begin tests_failed++; $display("FAIL l9_early: got %0d required 1", cur_level); end
        run_writes(37, 1'b0, to, f, l);
        tests_run++; if (to) begin tests_failed++; $display("FAIL l9_timeout: got timeout required 37 writes"); end
        tests_run++; if (cur_level !== 4'd9) begin tests_failed++; $display("FAIL l9_level: got %0d required 9", cur_level); end
    endtask

    task automatic test_invalid_level;
        bit to; int f; int l;
        strobe(4'd3);
        push_n(9 * A, 12);
        push_n(-3 * A, 10);
        run_writes(22, 1'b0, to, f, l);
        tests_run++; if (cur_level !== 4'd3) begin tests_failed++; $display("FAIL l3_level: got %0d required 3", cur_level); end
        idle(600);
        strobe(4'd12);
        idle(500);
        push_n(-3 * A, 26);
        push_n(3 * A, 36);
        push_n(-3 * A, 4);
        run_writes(66, 1'b0, to, f, l);
        tests_run++; if (to) begin tests_failed++; $display("FAIL l12_timeout: got timeout required 66 writes"); end
        tests_run++; if (cur_level !== 4'd3) begin tests_failed++; $display("FAIL l12_level: got %0d required 3", cur_level); end
    endtask

    task automatic test_timeout;
        bit to; int f; int l;
        idle(1100);
        push_n(-3 * A, 32);
        push_n(0, 4);
        run_writes(31, 1'b0, to, f, l);
        tests_run++; if (muted !== 1'b0) begin tests_failed++; $display("FAIL tmo_early: got muted=%b required 0", muted); end
        run_writes(5, 1'b0, to, f, l);
        tests_run++; if (to) begin tests_failed++; $display("FAIL tmo_timeout: got timeout required 5 writes"); end
        tests_run++; if (muted !== 1'b1) begin tests_failed++; $display("FAIL tmo_muted: got %b required 1", muted); end
        tests_run++; if (cur_level !== 4'd0) begin tests_failed++; $display("FAIL tmo_level: got %0d required 0", cur_level); end
    endtask

    task automatic test_allowed_low;
        int w0;
        enable = 1'b1;
        audio_out_allowed = 1'b0;
        w0 = writes_seen;
        idle(20);
        tests_run++; if (writes_seen !== w0) begin tests_failed++; $display("FAIL allow_low: got %0d writes required 0", writes_seen - w0); end
    endtask

    task automatic test_enable_drop;
        bit to; int f; int l; int w0;
        strobe(4'd5);
        push_n(0, 1);
        push_n(5 * A, 10);
        run_writes(11, 1'b1, to, f, l);
        w0 = writes_seen;
        idle(20);
        tests_run++; if (writes_seen !== w0) begin tests_failed++; $display("FAIL en_low: got %0d writes required 0", writes_seen - w0); end
        tests_run++; if (cur_level !== 4'd5) begin tests_failed++; $display("FAIL en_level: got %0d required 5", cur_level); end
        push_n(5 * A, 18);
        push_n(-5 * A, 28);
        push_n(5 * A, 2);
        run_writes(48, 1'b1, to, f, l);
        tests_run++; if (to) begin tests_failed++; $display("FAIL en_timeout: got timeout required 48 writes"); end
    endtask

    task automatic test_reset_mid_write;
        bit got;
        got = 1'b0;
        push_n(5 * A, 1);
        enable = 1'b1;
        audio_out_allowed = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge CLOCK_50); #1;
            if (write_audio_out) begin got = 1'b1; break; end
        end
        tests_run++; if (!got) begin tests_failed++; $display("FAIL rmw_nowrite: got no write required one"); end
        reset = 1'b1;
        enable = 1'b0;
        audio_out_allowed = 1'b0;
        @(posedge CLOCK_50); #1;
        tests_run++; if (write_audio_out !== 1'b0) begin tests_failed++; $display("FAIL rmw_write: got %b required 0", write_audio_out); end
        tests_run++; if (left_out !== 32'sd0) begin tests_failed++; $display("FAIL rmw_left: got %0d required 0", left_out); end
        tests_run++; if (right_out !== 32'sd0) begin tests_failed++; $display("FAIL rmw_right: got %0d required 0", right_out); end
        tests_run++; if (cur_level !== 4'd0) begin tests_failed++; $display("FAIL rmw_level: got %0d required 0", cur_level); end
        tests_run++; if (muted !== 1'b1) begin tests_failed++; $display("FAIL rmw_muted: got %b required 1", muted); end
        reset = 1'b0;
        idle(2);
        tests_run++; if (sb_q.size() !== 0) begin tests_failed++; $display("FAIL sb_leftover: got %0d pending required 0", sb_q.size()); end
    endtask

    initial begin
        test_reset();
        test_silent_writes();
        test_level_one();
        test_level_nine_mid();
        test_invalid_level();
        test_timeout();
        test_allowed_low();
        test_enable_drop();
        test_reset_mid_write();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
